// File: rtl/tama_pkg.sv
// Shared definitions for the tamagotchi input path: need indices, button slots,
// hold-timer encoding and the round-robin pick helper.
package tama_pkg;

    localparam logic [1:0] NEED_SALUD     = 2'd0;
    localparam logic [1:0] NEED_ENERGIA   = 2'd1;
    localparam logic [1:0] NEED_HAMBRE    = 2'd2;
    localparam logic [1:0] NEED_DIVERSION = 2'd3;

    localparam int BTN_RESET = 4;
    localparam int BTN_TEST  = 5;

    typedef enum logic [1:0] {
        HOLD_IDLE  = 2'd0,
        HOLD_RUN   = 2'd1,
        HOLD_FIRED = 2'd2
    } hold_state_e;

    typedef enum logic {
        OWNER_RESET = 1'b0,
        OWNER_TEST  = 1'b1
    } hold_owner_e;

    // First requesting index at or after ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tama_input_ctrl_if.sv
// Need-command valid/ready channel between the input controller and the game FSM.
interface tama_input_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_sel;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_sel, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_sel, output cmd_ready);
endinterface

// File: rtl/tama_debounce.sv
// One-bit two-flop synchronizer followed by a stability-count debouncer.
module tama_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count only advances while the synced input disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/tama_input_ctrl.sv
// Button front end: debounces six buttons, arbitrates need presses round-robin
// onto a valid/ready channel and turns reset/test long-presses into game commands.
module tama_input_ctrl
    import tama_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int SEC_CYCLES = 50_000_000,
    parameter int HOLD_SEC   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_salud_raw,
    input  logic                      btn_energia_raw,
    input  logic                      btn_hambre_raw,
    input  logic                      btn_diversion_raw,
    input  logic                      btn_reset_raw,
    input  logic                      btn_test_raw,
    tama_input_ctrl_if.master         cmd,
    output logic                      game_reset,
    output logic                      test_active,
    output logic [2:0]                hold_secs
);
    localparam int SEC_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SEC_CYCLES - 1);
    // The cycle in which the button is first seen held counts toward the first second.
    localparam logic [SEC_W-1:0] SEC_START = (SEC_CYCLES > 1) ? SEC_W'(1) : SEC_W'(0);

    logic [5:0] raw_vec;
    logic [5:0] db_vec;

    assign raw_vec = {btn_test_raw, btn_reset_raw, btn_diversion_raw,
                      btn_hambre_raw, btn_energia_raw, btn_salud_raw};

    for (genvar g = 0; g < 6; g++) begin : g_deb
        tama_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[g]),
            .level (db_vec[g])
        );
    end

    logic       reset_db, test_db;
    logic [3:0] need_db;
    logic [3:0] need_prev_q;
    logic [3:0] rise, eff_req;
    logic [3:0] pending_q, pending_d;
    logic       valid_q, valid_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] rr_q, rr_d;

    hold_state_e      state_q, state_d;
    hold_owner_e      owner_q, owner_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [2:0]       hold_q, hold_d, hold_inc;
    logic             game_reset_q, game_reset_d;
    logic             test_active_q, test_active_d;
    logic             owner_level;

    assign reset_db = db_vec[BTN_RESET];
    assign test_db  = db_vec[BTN_TEST];
    assign need_db  = db_vec[3:0];
    assign rise     = need_db & ~need_prev_q;
    // A press arriving this cycle is eligible for the grant immediately.
    assign eff_req  = pending_q | rise;

    always_comb begin
        pending_d = pending_q | rise;
        valid_d   = valid_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        if (valid_q && cmd.cmd_ready) begin
            pending_d[sel_q] = rise[sel_q];
            rr_d             = sel_q + 2'd1;
            valid_d          = 1'b0;
        end else if (!valid_q && (|eff_req)) begin
            valid_d = 1'b1;
            sel_d   = rr_pick(eff_req, rr_q);
        end
        if (game_reset_q) begin
            pending_d = '0;
            rr_d      = '0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            need_prev_q <= '0;
            pending_q   <= '0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
            rr_q        <= '0;
        end else begin
            need_prev_q <= need_db;
            pending_q   <= pending_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
        end
    end

    assign owner_level = (owner_q == OWNER_TEST) ? test_db : reset_db;
    assign hold_inc    = hold_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        sec_d         = sec_q;
        hold_d        = hold_q;
        game_reset_d  = 1'b0;
        test_active_d = test_active_q;
        case (state_q)
            HOLD_IDLE: begin
                sec_d  = '0;
                hold_d = '0;
                if (reset_db) begin
                    state_d = HOLD_RUN;
                    owner_d = OWNER_RESET;
                    sec_d   = SEC_START;
                end else if (test_db) begin
                    state_d = HOLD_RUN;
                    owner_d = OWNER_TEST;
                    sec_d   = SEC_START;
                end
            end
            HOLD_RUN: begin
                if (owner_q == OWNER_TEST && reset_db) begin
                    owner_d = OWNER_RESET;
                    sec_d   = SEC_START;
                    hold_d  = '0;
                end else if (!owner_level) begin
                    state_d = HOLD_IDLE;
                    sec_d   = '0;
                    hold_d  = '0;
                end else if (sec_q == SEC_LAST) begin
                    sec_d  = '0;
                    hold_d = hold_inc;
                    if (hold_inc == 3'(HOLD_SEC)) begin
                        state_d = HOLD_FIRED;
                        if (owner_q == OWNER_RESET) begin
                            game_reset_d  = 1'b1;
                            test_active_d = 1'b0;
                        end else begin
                            test_active_d = ~test_active_q;
                        end
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
            HOLD_FIRED: begin
                if (!owner_level) begin
                    state_d = HOLD_IDLE;
                    sec_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = HOLD_IDLE;
                sec_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HOLD_IDLE;
            owner_q       <= OWNER_RESET;
            sec_q         <= '0;
            hold_q        <= '0;
            game_reset_q  <= 1'b0;
            test_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            sec_q         <= sec_d;
            hold_q        <= hold_d;
            game_reset_q  <= game_reset_d;
            test_active_q <= test_active_d;
        end
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_sel   = sel_q;
    assign game_reset    = game_reset_q;
    assign test_active   = test_active_q;
    assign hold_secs     = hold_q;

endmodule

// File: tb/tb_tama_input_ctrl.sv
// Directed bench for tama_input_ctrl with short debounce and second timing.
module tb_tama_input_ctrl;
    import tama_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       btn_salud_raw, btn_energia_raw, btn_hambre_raw;
    logic       btn_diversion_raw, btn_reset_raw, btn_test_raw;
    logic       game_reset, test_active;
    logic [2:0] hold_secs;

    int errors = 0;
    int checks = 0;

    tama_input_ctrl_if bus ();

    tama_input_ctrl #(
        .DEB_CYCLES (4),
        .SEC_CYCLES (10),
        .HOLD_SEC   (5)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .btn_salud_raw     (btn_salud_raw),
        .btn_energia_raw   (btn_energia_raw),
        .btn_hambre_raw    (btn_hambre_raw),
        .btn_diversion_raw (btn_diversion_raw),
        .btn_reset_raw     (btn_reset_raw),
        .btn_test_raw      (btn_test_raw),
        .cmd               (bus.master),
        .game_reset        (game_reset),
        .test_active       (test_active),
        .hold_secs         (hold_secs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Button vector order: {test, reset, diversion, hambre, energia, salud}.
    task automatic applyStimulus(input logic [5:0] btns, input logic ready);
        btn_salud_raw     = btns[0];
        btn_energia_raw   = btns[1];
        btn_hambre_raw    = btns[2];
        btn_diversion_raw = btns[3];
        btn_reset_raw     = btns[4];
        btn_test_raw      = btns[5];
        bus.cmd_ready     = ready;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seen;
        int bad;
        int ng;
        int pulses;
        int pulse_at;
        int ta_seen;
        logic [1:0] grants [8];

        // Reset state
        applyStimulus(6'b000000, 1'b0);
        rst_n = 1'b0;
        tick(3);
        checkOutput("rst_valid", int'(bus.cmd_valid), 0);
        checkOutput("rst_sel", int'(bus.cmd_sel), 0);
        checkOutput("rst_game_reset", int'(game_reset), 0);
        checkOutput("rst_test_active", int'(test_active), 0);
        checkOutput("rst_hold_secs", int'(hold_secs), 0);
        rst_n = 1'b1;
        tick(2);

        // A 3-cycle energia glitch must never reach the arbiter
        applyStimulus(6'b000010, 1'b0);
        tick(3);
        applyStimulus(6'b000000, 1'b0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (bus.cmd_valid) seen++;
        end
        checkOutput("glitch_no_valid", seen, 0);

        // Held energia: grant appears exactly 2+4+1 cycles after press
        applyStimulus(6'b000010, 1'b0);
        tick(6);
        checkOutput("deb_latency_early", int'(bus.cmd_valid), 0);
        tick(1);
        checkOutput("deb_latency_valid", int'(bus.cmd_valid), 1);
        checkOutput("deb_latency_sel", int'(bus.cmd_sel), int'(NEED_ENERGIA));
        tick(3);
        applyStimulus(6'b000000, 1'b1);
        tick(1);
        checkOutput("energia_accept_drop", int'(bus.cmd_valid), 0);
        applyStimulus(6'b000000, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.cmd_valid) seen++;
        end
        checkOutput("energia_no_regrant", seen, 0);

        // Hambre stalled by cmd_ready=0 holds a stable offer
        applyStimulus(6'b000100, 1'b0);
        tick(7);
        checkOutput("stall_valid", int'(bus.cmd_valid), 1);
        checkOutput("stall_sel", int'(bus.cmd_sel), int'(NEED_HAMBRE));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!(bus.cmd_valid && bus.cmd_sel == NEED_HAMBRE)) bad++;
        end
        checkOutput("stall_stable", bad, 0);
        applyStimulus(6'b000000, 1'b1);
        tick(1);
        checkOutput("stall_accept_drop", int'(bus.cmd_valid), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (bus.cmd_valid) seen++;
        end
        checkOutput("stall_no_second_grant", seen, 0);
        applyStimulus(6'b000000, 1'b0);

        // Clear the round-robin pointer before the ordering test
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // All four needs at once, always ready: grants 0,1,2,3
        applyStimulus(6'b001111, 1'b1);
        ng = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.cmd_valid && ng < 8) begin
                grants[ng] = bus.cmd_sel;
                ng++;
            end
        end
        checkOutput("rr_count", ng, 4);
        checkOutput("rr_grant0", int'(grants[0]), int'(NEED_SALUD));
        checkOutput("rr_grant1", int'(grants[1]), int'(NEED_ENERGIA));
        checkOutput("rr_grant2", int'(grants[2]), int'(NEED_HAMBRE));
        checkOutput("rr_grant3", int'(grants[3]), int'(NEED_DIVERSION));
        applyStimulus(6'b000000, 1'b1);
        tick(10);

        // Pointer wrapped to 0: salud then diversion
        applyStimulus(6'b001001, 1'b1);
        ng = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.cmd_valid && ng < 8) begin
                grants[ng] = bus.cmd_sel;
                ng++;
            end
        end
        checkOutput("rr2_count", ng, 2);
        checkOutput("rr2_grant0", int'(grants[0]), int'(NEED_SALUD));
        checkOutput("rr2_grant1", int'(grants[1]), int'(NEED_DIVERSION));
        applyStimulus(6'b000000, 1'b0);
        tick(10);

        // Long reset press with a stalled salud offer outstanding
        applyStimulus(6'b010001, 1'b0);
        pulses = 0;
        pulse_at = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (game_reset) begin
                pulses++;
                pulse_at = i;
            end
            if (i == 10) applyStimulus(6'b010000, 1'b0);
            if (i == 15) checkOutput("hold_before_1s", int'(hold_secs), 0);
            if (i == 16) checkOutput("hold_1s", int'(hold_secs), 1);
            if (i == 26) checkOutput("hold_2s", int'(hold_secs), 2);
            if (i == 36) checkOutput("hold_3s", int'(hold_secs), 3);
            if (i == 46) checkOutput("hold_4s", int'(hold_secs), 4);
            if (i == 56) checkOutput("hold_5s", int'(hold_secs), 5);
            if (i == 56) checkOutput("valid_at_fire", int'(bus.cmd_valid), 1);
            if (i == 57) checkOutput("valid_after_fire", int'(bus.cmd_valid), 0);
            if (i == 60) checkOutput("hold_saturated", int'(hold_secs), 5);
        end
        checkOutput("long_reset_pulses", pulses, 1);
        checkOutput("long_reset_pulse_cycle", pulse_at, 56);
        applyStimulus(6'b000000, 1'b0);
        tick(6);
        checkOutput("fired_hold_kept", int'(hold_secs), 5);
        tick(1);
        checkOutput("fired_release_idle", int'(hold_secs), 0);
        checkOutput("pending_cleared", int'(bus.cmd_valid), 0);
        tick(5);

        // Reset released after 45 cycles: nothing fires
        applyStimulus(6'b010000, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 70; i++) begin
            tick(1);
            if (game_reset) pulses++;
            if (i == 45) applyStimulus(6'b000000, 1'b0);
            if (i == 51) checkOutput("short_hold_4s", int'(hold_secs), 4);
            if (i == 52) checkOutput("short_hold_idle", int'(hold_secs), 0);
        end
        checkOutput("short_reset_pulses", pulses, 0);

        // Two test long-presses toggle test_active 0 -> 1 -> 0
        for (int n = 0; n < 2; n++) begin
            applyStimulus(6'b100000, 1'b0);
            pulses = 0;
            for (int i = 1; i <= 60; i++) begin
                tick(1);
                if (game_reset) pulses++;
                if (i == 55) checkOutput("test_before_fire", int'(test_active), (n == 0) ? 0 : 1);
                if (i == 56) checkOutput("test_after_fire", int'(test_active), (n == 0) ? 1 : 0);
            end
            checkOutput("test_no_game_reset", pulses, 0);
            applyStimulus(6'b000000, 1'b0);
            tick(12);
        end

        // Test held, then reset joins: timer restarts for reset
        applyStimulus(6'b100000, 1'b0);
        pulses = 0;
        pulse_at = 0;
        ta_seen = 0;
        for (int i = 1; i <= 95; i++) begin
            tick(1);
            if (game_reset) begin
                pulses++;
                pulse_at = i;
            end
            if (test_active) ta_seen++;
            if (i == 30) applyStimulus(6'b110000, 1'b0);
            if (i == 36) checkOutput("prio_test_hold_3s", int'(hold_secs), 3);
            if (i == 37) checkOutput("prio_restart_zero", int'(hold_secs), 0);
        end
        checkOutput("prio_pulses", pulses, 1);
        checkOutput("prio_pulse_cycle", pulse_at, 86);
        checkOutput("prio_test_never_set", ta_seen, 0);
        applyStimulus(6'b000000, 1'b0);
        tick(12);

        // rst_n mid-handshake and mid-hold discards everything
        applyStimulus(6'b010100, 1'b0);
        tick(36);
        checkOutput("midop_valid", int'(bus.cmd_valid), 1);
        checkOutput("midop_sel", int'(bus.cmd_sel), int'(NEED_HAMBRE));
        checkOutput("midop_hold", int'(hold_secs), 3);
        rst_n = 1'b0;
        applyStimulus(6'b000000, 1'b0);
        tick(1);
        checkOutput("midop_rst_valid", int'(bus.cmd_valid), 0);
        checkOutput("midop_rst_sel", int'(bus.cmd_sel), 0);
        checkOutput("midop_rst_game_reset", int'(game_reset), 0);
        checkOutput("midop_rst_test_active", int'(test_active), 0);
        checkOutput("midop_rst_hold", int'(hold_secs), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.cmd_valid || hold_secs != 3'd0) seen++;
        end
        checkOutput("midop_nothing_after", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
